// File: rtl/picodevice_axi_ram.sv
// picodevice_axi_ram: AXI4-lite slave RAM answering the core complex's mem_axi_*
// master port. One outstanding write and one outstanding read, byte-strobed
// writes, single-cycle registered reads, read-before-write on same-word collision.
// Optional macro PICODEVICE_AXI_RAM_SLVERR_EN adds an address range check that
// answers out-of-range accesses with SLVERR instead of aliasing into the RAM.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; this slave never withdraws a valid it has
// raised before that edge, and its readies depend only on internal state.
module picodevice_axi_ram #(
   parameter int          MEM_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter              INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_axi_awvalid,
   output logic        mem_axi_awready,
   input  logic [31:0] mem_axi_awaddr,
   input  logic [2:0]  mem_axi_awprot,
   input  logic        mem_axi_wvalid,
   output logic        mem_axi_wready,
   input  logic [31:0] mem_axi_wdata,
   input  logic [3:0]  mem_axi_wstrb,
   output logic        mem_axi_bvalid,
   input  logic        mem_axi_bready,
   output logic [1:0]  mem_axi_bresp,
   input  logic        mem_axi_arvalid,
   output logic        mem_axi_arready,
   input  logic [31:0] mem_axi_araddr,
   input  logic [2:0]  mem_axi_arprot,
   output logic        mem_axi_rvalid,
   input  logic        mem_axi_rready,
   output logic [31:0] mem_axi_rdata,
   output logic [1:0]  mem_axi_rresp
);

   localparam int          AW     = $clog2(MEM_WORDS);
   localparam logic [31:0] SPAN   = 32'(MEM_WORDS * 4);
   localparam logic [1:0]  OKAY   = 2'b00;
   localparam logic [1:0]  SLVERR = 2'b10;

   typedef enum logic {R_IDLE, R_RESP} rd_state_t;

   logic [31:0]   mem [MEM_WORDS];

   logic          up;
   logic          aw_full;
   logic          w_full;
   logic [31:0]   aw_addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          bvalid_q;
   logic [1:0]    bresp_q;
   rd_state_t     rd_state;
   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q;

   logic          aw_hs;
   logic          w_hs;
   logic          ar_hs;
   logic          commit;
   logic [31:0]   wr_off;
   logic [31:0]   rd_off;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic          wr_ok;
   logic          rd_ok;
   logic          unused_bits;

   assign mem_axi_awready = up & ~aw_full;
   assign mem_axi_wready  = up & ~w_full;
   assign mem_axi_arready = up & (rd_state == R_IDLE);
   assign mem_axi_bvalid  = bvalid_q;
   assign mem_axi_bresp   = bresp_q;
   assign mem_axi_rvalid  = rvalid_q;
   assign mem_axi_rdata   = rdata_q;
   assign mem_axi_rresp   = rresp_q;

   assign aw_hs  = mem_axi_awvalid & mem_axi_awready;
   assign w_hs   = mem_axi_wvalid & mem_axi_wready;
   assign ar_hs  = mem_axi_arvalid & mem_axi_arready;
   // A commit needs both halves of the write and a free B channel.
   assign commit = aw_full & w_full & ~bvalid_q;

   // Offsets wrap below BASE_ADDR, which makes them fail the range check.
   assign wr_off = aw_addr_q - BASE_ADDR;
   assign rd_off = mem_axi_araddr - BASE_ADDR;
   assign wr_idx = wr_off[AW+1:2];
   assign rd_idx = rd_off[AW+1:2];

`ifdef PICODEVICE_AXI_RAM_SLVERR_EN
   assign wr_ok = (wr_off < SPAN);
   assign rd_ok = (rd_off < SPAN);
`else
   // Without the range check every address aliases into the RAM.
   assign wr_ok = 1'b1;
   assign rd_ok = 1'b1;
`endif

   assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot, wr_off[1:0], rd_off[1:0],
                          wr_off[31:AW+2], rd_off[31:AW+2], SPAN[0]};

   // Write channel holding registers, commit and B response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         up        <= 1'b0;
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
      end else begin
         up <= 1'b1;
         if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_addr_q <= mem_axi_awaddr;
         end else if (commit) begin
            aw_full <= 1'b0;
         end
         if (w_hs) begin
            w_full  <= 1'b1;
            wdata_q <= mem_axi_wdata;
            wstrb_q <= mem_axi_wstrb;
         end else if (commit) begin
            w_full <= 1'b0;
         end
         if (commit) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? OKAY : SLVERR;
         end else if (bvalid_q && mem_axi_bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

   // RAM byte writes; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (commit && wr_ok) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   // Read FSM: sample the RAM on the AR handshake, hold R until accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state <= R_IDLE;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rresp_q  <= OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state <= R_RESP;
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_ok ? mem[rd_idx] : 32'h0000_0000;
                  rresp_q  <= rd_ok ? OKAY : SLVERR;
               end
            end
            R_RESP: begin
               if (mem_axi_rready) begin
                  rd_state <= R_IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_picodevice_axi_ram.sv
// Directed bench for picodevice_axi_ram: reset, write/read, strobes, channel
// skew, B and R backpressure, read/write collision, reset mid-transaction and
// out-of-range handling for whichever build of the range check is compiled.
module tb_picodevice_axi_ram;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid;
   logic        bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] araddr = '0;
   logic [2:0]  arprot = '0;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   int checks = 0;
   int errors = 0;

   picodevice_axi_ram #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .INIT_FILE("")) dut (
      .clk(clk), .reset(reset),
      .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr),
      .mem_axi_awprot(awprot),
      .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata),
      .mem_axi_wstrb(wstrb),
      .mem_axi_bvalid(bvalid), .mem_axi_bready(bready), .mem_axi_bresp(bresp),
      .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr),
      .mem_axi_arprot(arprot),
      .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
      .mem_axi_rresp(rresp)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Driver: AW and W presented together, bready high; lat = edges from handshake to bvalid.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp, output int lat);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      aw_done = 0; w_done = 0; n = 0; resp = 2'b11; lat = -1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (aw_done && w_done) begin
         lat = 0;
         while (!bvalid && lat < 20) begin tick(); lat++; end
         if (!bvalid) lat = -1;
         resp = bresp;
         tick();
      end
      bready = 1'b0;
   endtask

   // Driver: AR then R with rready high; lat = 1 when rvalid is up right after the AR edge.
   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
      bit done, hs;
      int n;
      araddr = addr; arvalid = 1'b1; rready = 1'b1;
      done = 0; n = 0; lat = -1; data = 32'hxxxx_xxxx; resp = 2'b11;
      while (!done && n < 20) begin
         hs = arready;
         tick();
         if (hs) done = 1;
         n++;
      end
      arvalid = 1'b0;
      if (done) begin
         lat = 1;
         while (!rvalid && lat < 20) begin tick(); lat++; end
         if (!rvalid) lat = -1;
         data = rdata;
         resp = rresp;
         tick();
      end
      rready = 1'b0;
   endtask

   task automatic test_reset;
      tick(); tick();
      checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready got %b exp 0", awready); end
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b exp 0", wready); end
      checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready got %b exp 0", arready); end
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b exp 0", bvalid); end
      checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", rvalid); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rdata); end
      checks++; if ({bresp, rresp} !== 4'h0) begin errors++; $display("FAIL rst_resp got %b exp 0000", {bresp, rresp}); end
      reset = 1'b0;
      checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rel_awready_early got %b exp 0", awready); end
      tick();
      checks++; if ({awready, wready, arready} !== 3'b111) begin errors++; $display("FAIL rel_readies got %b exp 111", {awready, wready, arready}); end
   endtask

   task automatic test_write_read;
      logic [1:0] resp; logic [31:0] data; int lat;
      axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, resp, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL wr_lat got %0d exp 1", lat); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wr_bresp got %b exp 00", resp); end
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL wr_bvalid_clear got %b exp 0", bvalid); end
      axi_read(32'h10, data, resp, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL rd_lat got %0d exp 1", lat); end
      checks++; if (data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", data); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL rd_rresp got %b exp 00", resp); end
   endtask

   task automatic test_strobes;
      logic [1:0] resp; logic [31:0] data; int lat;
      axi_write(32'h20, 32'h1122_3344, 4'hF, resp, lat);
      axi_write(32'h20, 32'hAABB_CCDD, 4'b0101, resp, lat);
      axi_read(32'h20, data, resp, lat);
      checks++; if (data !== 32'h11BB_33DD) begin errors++; $display("FAIL strb_0101 got %h exp 11bb33dd", data); end
      axi_write(32'h20, 32'hFFFF_FFFF, 4'h0, resp, lat);
      checks++; if (lat !== 1) begin errors++; $display("FAIL strb0_bvalid_lat got %0d exp 1", lat); end
      axi_read(32'h20, data, resp, lat);
      checks++; if (data !== 32'h11BB_33DD) begin errors++; $display("FAIL strb0_data got %h exp 11bb33dd", data); end
   endtask

   task automatic test_skew;
      logic [1:0] resp; logic [31:0] data; int lat;
      bready = 1'b1;
      wdata = 32'h55AA_55AA; wstrb = 4'hF; wvalid = 1'b1;
      checks++; if (wready !== 1'b1) begin errors++; $display("FAIL skew_wready_pre got %b exp 1", wready); end
      tick();
      wvalid = 1'b0;
      checks++; if (wready !== 1'b0) begin errors++; $display("FAIL skew_wready_full got %b exp 0", wready); end
      tick(); tick();
      checks++; if ({bvalid, wready} !== 2'b00) begin errors++; $display("FAIL skew_wait got %b exp 00", {bvalid, wready}); end
      awaddr = 32'h40; awvalid = 1'b1;
      checks++; if (awready !== 1'b1) begin errors++; $display("FAIL skew_awready got %b exp 1", awready); end
      tick();
      awvalid = 1'b0;
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL skew_b_early got %b exp 0", bvalid); end
      tick();
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL skew_b_commit got %b exp 1", bvalid); end
      tick();
      checks++; if ({bvalid, wready} !== 2'b01) begin errors++; $display("FAIL skew_b_done got %b exp 01", {bvalid, wready}); end
      tick();
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL skew_single_commit got %b exp 0", bvalid); end
      bready = 1'b0;
      axi_read(32'h40, data, resp, lat);
      checks++; if (data !== 32'h55AA_55AA) begin errors++; $display("FAIL skew_data got %h exp 55aa55aa", data); end
   endtask

   task automatic test_b_backpressure;
      logic [1:0] resp; logic [31:0] data; int lat;
      bready = 1'b0;
      awaddr = 32'h50; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      tick();
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bp_first_b got %b exp 1", bvalid); end
      awaddr = 32'h54; wdata = 32'h9ABC_DEF0; awvalid = 1'b1; wvalid = 1'b1;
      checks++; if ({awready, wready} !== 2'b11) begin errors++; $display("FAIL bp_second_accept got %b exp 11", {awready, wready}); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
            errors++; $display("FAIL bp_hold%0d got %b exp 10000", i, {bvalid, bresp, awready, wready});
         end
         tick();
      end
      bready = 1'b1;
      tick();
      checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL bp_gap got %b exp 0", bvalid); end
      tick();
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL bp_second_b got %b exp 1", bvalid); end
      tick();
      bready = 1'b0;
      axi_read(32'h54, data, resp, lat);
      checks++; if (data !== 32'h9ABC_DEF0) begin errors++; $display("FAIL bp_data54 got %h exp 9abcdef0", data); end
      axi_read(32'h50, data, resp, lat);
      checks++; if (data !== 32'h1234_5678) begin errors++; $display("FAIL bp_data50 got %h exp 12345678", data); end
   endtask

   task automatic test_r_backpressure;
      logic [1:0] resp; int lat;
      axi_write(32'h60, 32'hCAFE_F00D, 4'hF, resp, lat);
      rready = 1'b0; araddr = 32'h60; arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({rvalid, arready, rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            errors++; $display("FAIL rbp_hold%0d got %b/%b/%h exp 1/0/cafef00d", i, rvalid, arready, rdata);
         end
         tick();
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checks++; if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL rbp_release got %b exp 01", {rvalid, arready}); end
      checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rbp_rdata_hold got %h exp cafef00d", rdata); end
   endtask

   task automatic test_collision;
      logic [1:0] resp; logic [31:0] data; int lat;
      axi_write(32'h30, 32'h1, 4'hF, resp, lat);
      awaddr = 32'h30; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      araddr = 32'h30; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      checks++; if ({rvalid, bvalid} !== 2'b11) begin errors++; $display("FAIL col_same_edge got %b exp 11", {rvalid, bvalid}); end
      checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL col_old_data got %h exp 00000001", rdata); end
      rready = 1'b1; bready = 1'b1;
      tick();
      rready = 1'b0; bready = 1'b0;
      axi_read(32'h30, data, resp, lat);
      checks++; if (data !== 32'h2) begin errors++; $display("FAIL col_new_data got %h exp 00000002", data); end
   endtask

   task automatic test_reset_midop;
      logic [1:0] resp; logic [31:0] data; int lat;
      axi_write(32'h70, 32'h0BAD_BEEF, 4'hF, resp, lat);
      awaddr = 32'h74; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      araddr = 32'h70; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      checks++; if ({rvalid, awready} !== 2'b10) begin errors++; $display("FAIL mid_pre got %b exp 10", {rvalid, awready}); end
      reset = 1'b1;
      #1;
      checks++;
      if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== 41'h0) begin
         errors++; $display("FAIL mid_async got %b %b %b %b %b %b %b %h exp all 0",
                           awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata);
      end
      tick();
      reset = 1'b0;
      checks++; if ({awready, wready, arready} !== 3'b000) begin errors++; $display("FAIL mid_rel_early got %b exp 000", {awready, wready, arready}); end
      tick();
      checks++; if ({awready, wready, arready, rvalid} !== 4'b1110) begin errors++; $display("FAIL mid_rel_up got %b exp 1110", {awready, wready, arready, rvalid}); end
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      tick();
      wvalid = 1'b0;
      tick(); tick();
      checks++; if ({bvalid, awready} !== 2'b01) begin errors++; $display("FAIL mid_no_stale got %b exp 01", {bvalid, awready}); end
      awaddr = 32'h78; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      tick();
      checks++; if (bvalid !== 1'b1) begin errors++; $display("FAIL mid_fresh_b got %b exp 1", bvalid); end
      tick();
      bready = 1'b0;
      axi_read(32'h70, data, resp, lat);
      checks++; if (data !== 32'h0BAD_BEEF) begin errors++; $display("FAIL mid_preserved got %h exp 0badbeef", data); end
      axi_read(32'h78, data, resp, lat);
      checks++; if (data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mid_fresh_data got %h exp ffffffff", data); end
   endtask

   task automatic test_out_of_range;
      logic [1:0] resp; logic [31:0] data; int lat;
      axi_write(32'h0, 32'hA5A5_A5A5, 4'hF, resp, lat);
      axi_write(32'h1000, 32'h5A5A_5A5A, 4'hF, resp, lat);
`ifdef PICODEVICE_AXI_RAM_SLVERR_EN
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_bresp got %b exp 10", resp); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL oor_wr_lat got %0d exp 1", lat); end
      axi_read(32'h0, data, resp, lat);
      checks++; if (data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL oor_word0 got %h exp a5a5a5a5", data); end
      axi_read(32'h1000, data, resp, lat);
      checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oor_rresp got %b exp 10", resp); end
      checks++; if (data !== 32'h0) begin errors++; $display("FAIL oor_rdata got %h exp 00000000", data); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL oor_rd_lat got %0d exp 1", lat); end
`else
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL alias_bresp got %b exp 00", resp); end
      axi_read(32'h0, data, resp, lat);
      checks++; if (data !== 32'h5A5A_5A5A) begin errors++; $display("FAIL alias_word0 got %h exp 5a5a5a5a", data); end
      checks++; if (resp !== 2'b00) begin errors++; $display("FAIL alias_rresp got %b exp 00", resp); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_strobes();
      test_skew();
      test_b_backpressure();
      test_r_backpressure();
      test_collision();
      test_reset_midop();
      test_out_of_range();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
